// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory loader.
// States are plain 4-bit codes so older tools can consume them.
package imem_loader_pkg;

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_COUNT = 4'd1;
  localparam logic [3:0] ST_B0    = 4'd2;
  localparam logic [3:0] ST_B1    = 4'd3;
  localparam logic [3:0] ST_B2    = 4'd4;
  localparam logic [3:0] ST_WRITE = 4'd5;
  localparam logic [3:0] ST_CHECK = 4'd6;
  localparam logic [3:0] ST_DONE  = 4'd7;
  localparam logic [3:0] ST_ERROR = 4'd8;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int unsigned BYTES_PER_WORD = 3;

  function automatic logic [19:0] pack_word(
    input logic [3:0] hi,
    input logic [7:0] b1,
    input logic [7:0] b0
  );
    return {hi, b1, b0};
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Host byte stream plus instruction-memory write port.
// The loader is the slave side; host/memory is the master side.
interface imem_loader_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 20
);
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_wdata;

  modport master (
    output rx_valid,
    output rx_data,
    input  rx_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

  modport slave (
    input  rx_valid,
    input  rx_data,
    output rx_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );
endinterface

// File: rtl/imem_loader_timeout.sv
// Inter-byte stall counter for an open frame.
// expired_o fires on the edge that would complete TIMEOUT_CYCLES stalls.
module loader_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired_o = en_i &&
    (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader: fills instruction memory and
// holds the core in reset until a checksummed frame lands.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 20,
  parameter int unsigned ADDRESS_WIDTH  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter bit          HOLD_ON_RESET  = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  imem_loader_if.slave             bus,
  output logic                     cpu_rst_n,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [ADDRESS_WIDTH-1:0] words_loaded
);

  logic [3:0]               state_q, state_d;
  logic [7:0]               chk_q, chk_d;
  logic [7:0]               rem_q, rem_d;
  logic [7:0]               b0_q, b0_d;
  logic [7:0]               b1_q, b1_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [ADDRESS_WIDTH-1:0] words_q, words_d;
  logic rdy_q, rdy_d;
  logic we_q, we_d;
  logic cpu_q, cpu_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic err_q, err_d;
  logic accept, waiting, tmo, fail;
  logic [7:0] rx;

  assign rx      = bus.rx_data;
  assign accept  = bus.rx_valid && rdy_q;
  assign waiting = state_q inside
    {ST_COUNT, ST_B0, ST_B1, ST_B2, ST_CHECK};

  loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (rst),
    .clr_i    (!waiting || accept),
    .en_i     (waiting && !accept),
    .expired_o(tmo)
  );

  always_comb begin
    state_d = state_q;
    chk_d   = chk_q;
    rem_d   = rem_q;
    b0_d    = b0_q;
    b1_d    = b1_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    words_d = words_q;
    cpu_d   = cpu_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    fail    = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (accept && rx == SYNC_BYTE) begin
          state_d = ST_COUNT;
          busy_d  = 1'b1;
          cpu_d   = 1'b0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          words_d = '0;
          addr_d  = '0;
          chk_d   = '0;
        end
      end
      ST_COUNT: begin
        if (accept) begin
          rem_d   = rx;
          chk_d   = rx;
          state_d = (rx == 8'd0) ? ST_CHECK : ST_B0;
        end
      end
      ST_B0: begin
        if (accept) begin
          b0_d    = rx;
          chk_d   = chk_q ^ rx;
          state_d = ST_B1;
        end
      end
      ST_B1: begin
        if (accept) begin
          b1_d    = rx;
          chk_d   = chk_q ^ rx;
          state_d = ST_B2;
        end
      end
      ST_B2: begin
        if (accept) begin
          unique case (1'b1)
            (rx[7:4] != 4'h0): fail = 1'b1;
            default: begin
              chk_d   = chk_q ^ rx;
              wdata_d = DATA_WIDTH'(
                pack_word(rx[3:0], b1_q, b0_q));
              state_d = ST_WRITE;
            end
          endcase
        end
      end
      ST_WRITE: begin
        addr_d  = addr_q + ADDRESS_WIDTH'(1);
        words_d = words_q + ADDRESS_WIDTH'(1);
        rem_d   = rem_q - 8'd1;
        state_d = (rem_q == 8'd1) ? ST_CHECK : ST_B0;
      end
      ST_CHECK: begin
        if (accept) begin
          if (rx == chk_q) begin
            state_d = ST_DONE;
            cpu_d   = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            fail = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort keeps whatever was already written to memory.
    if (fail || tmo) begin
      state_d = ST_ERROR;
      err_d   = 1'b1;
      busy_d  = 1'b0;
      cpu_d   = 1'b0;
    end
  end

  assign rdy_d = (state_d != ST_WRITE);
  assign we_d  = (state_d == ST_WRITE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      chk_q   <= '0;
      rem_q   <= '0;
      b0_q    <= '0;
      b1_q    <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
      words_q <= '0;
      rdy_q   <= 1'b1;
      we_q    <= 1'b0;
      cpu_q   <= !HOLD_ON_RESET;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      chk_q   <= chk_d;
      rem_q   <= rem_d;
      b0_q    <= b0_d;
      b1_q    <= b1_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      words_q <= words_d;
      rdy_q   <= rdy_d;
      we_q    <= we_d;
      cpu_q   <= cpu_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.rx_ready   = rdy_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign cpu_rst_n      = cpu_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = err_q;
  assign words_loaded   = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Loader bench: directed frames, stall/reset corners, then random
// frames checked against a word-level model of the frame rules.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int unsigned TMO = 16;
  localparam int unsigned BUDGET = 400000 * BYTES_PER_WORD;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpu_rst_n, busy, done, error;
  logic [7:0] words_loaded;

  int n_cmp = 0;
  int n_bad = 0;
  bit last_done = 1'b0;
  bit last_err  = 1'b0;

  logic [19:0] words_q[$];
  logic [27:0] wr_q[$];

  imem_loader_if #(.AW(8), .DW(20)) ifc ();

  imem_loader #(
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (ifc),
    .cpu_rst_n   (cpu_rst_n),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (ifc.imem_we === 1'b1)
      wr_q.push_back({ifc.imem_addr, ifc.imem_wdata});

  initial begin
    #(BUDGET);
    $display("FAIL watchdog: sim time %0t exceeded budget", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h",
             tag, obs, want);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send_byte(input logic [7:0] b);
    int guard;
    ifc.rx_valid = 1'b1;
    ifc.rx_data  = b;
    guard = 0;
    while (ifc.rx_ready !== 1'b1 && guard < 4) begin
      @(negedge clk);
      guard++;
    end
    if (guard == 4) check("rx_ready_stall", ifc.rx_ready, 1);
    @(negedge clk);
    ifc.rx_valid = 1'b0;
  endtask

  task automatic gsend(input logic [7:0] b, input int gmax);
    idle($urandom_range(0, gmax));
    send_byte(b);
  endtask

  task automatic check_reset(input string p);
    check({p, "_cpu_rst_n"}, cpu_rst_n, 0);
    check({p, "_rx_ready"}, ifc.rx_ready, 1);
    check({p, "_imem_we"}, ifc.imem_we, 0);
    check({p, "_imem_addr"}, ifc.imem_addr, 0);
    check({p, "_imem_wdata"}, ifc.imem_wdata, 0);
    check({p, "_busy"}, busy, 0);
    check({p, "_done"}, done, 0);
    check({p, "_error"}, error, 0);
    check({p, "_words"}, words_loaded, 0);
  endtask

  // Sends words_q as one frame; bad_idx truncates at a bad b2,
  // chk_flip corrupts the trailer.
  task automatic run_frame(input int bad_idx,
                           input logic [3:0] bad_nib,
                           input logic [7:0] chk_flip,
                           input int gmax);
    logic [7:0]  chk;
    logic [7:0]  b2;
    logic [19:0] w;
    logic [19:0] exp_q[$];
    bit err;
    int n;
    n = words_q.size();
    err = 1'b0;
    wr_q.delete();
    gsend(SYNC_BYTE, gmax);
    check("sync_busy", busy, 1);
    check("sync_done", done, 0);
    check("sync_error", error, 0);
    check("sync_cpu_rst_n", cpu_rst_n, 0);
    check("sync_words", words_loaded, 0);
    gsend(8'(n), gmax);
    chk = 8'(n);
    for (int i = 0; i < n; i++) begin
      w  = words_q[i];
      b2 = {(i == bad_idx) ? bad_nib : 4'h0, w[19:16]};
      gsend(w[7:0], gmax);
      gsend(w[15:8], gmax);
      gsend(b2, gmax);
      chk = chk ^ w[7:0] ^ w[15:8] ^ b2;
      if (i == bad_idx) begin
        err = 1'b1;
        break;
      end
      check("we_after_b2", ifc.imem_we, 1);
      check("addr_after_b2", ifc.imem_addr, i);
      check("wdata_after_b2", ifc.imem_wdata, w);
      check("ready_in_write", ifc.rx_ready, 0);
      exp_q.push_back(w);
    end
    if (!err) begin
      gsend(chk ^ chk_flip, gmax);
      err = (chk_flip != 8'h00);
    end
    check("end_error", error, err);
    check("end_done", done, !err);
    check("end_busy", busy, 0);
    check("end_cpu_rst_n", cpu_rst_n, !err);
    check("end_words", words_loaded, exp_q.size());
    check("end_rx_ready", ifc.rx_ready, 1);
    check("end_we", ifc.imem_we, 0);
    check("write_count", wr_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      check("wr_addr", wr_q[i][27:20], i);
      check("wr_data", wr_q[i][19:0], exp_q[i]);
    end
    last_done = !err;
    last_err  = err;
  endtask

  initial begin
    rst = 1'b0;
    ifc.rx_valid = 1'b0;
    ifc.rx_data  = 8'h00;
    idle(3);
    check_reset("rst_low");
    rst = 1'b1;
    idle(1);
    check_reset("rst_rel");

    words_q = '{20'h12345, 20'hABCDE};
    run_frame(-1, 4'h0, 8'h00, 0);

    run_frame(-1, 4'h0, 8'h03, 0);

    words_q = '{20'hFFFFF};
    run_frame(0, 4'h1, 8'h00, 0);

    words_q.delete();
    run_frame(-1, 4'h0, 8'h00, 0);
    wr_q.delete();
    send_byte(8'h33);
    idle(2 * TMO);
    check("garbage_done", done, 1);
    check("garbage_error", error, 0);
    check("garbage_busy", busy, 0);
    check("garbage_writes", wr_q.size(), 0);

    words_q = '{20'h0A5A5, 20'h3A5A5};
    run_frame(-1, 4'h0, 8'h00, 1);

    wr_q.delete();
    send_byte(SYNC_BYTE);
    send_byte(8'h01);
    idle(TMO - 1);
    send_byte(8'h45);
    check("stall_ok_error", error, 0);
    check("stall_ok_busy", busy, 1);
    idle(TMO);
    check("tmo_error", error, 1);
    check("tmo_busy", busy, 0);
    check("tmo_done", done, 0);
    check("tmo_cpu_rst_n", cpu_rst_n, 0);
    check("tmo_writes", wr_q.size(), 0);

    send_byte(SYNC_BYTE);
    send_byte(8'h02);
    send_byte(8'h45);
    send_byte(8'h23);
    send_byte(8'h01);
    send_byte(8'h45);
    check("mid_words", words_loaded, 1);
    check("mid_busy", busy, 1);
    #2 rst = 1'b0;
    #1 check_reset("async");
    @(negedge clk);
    rst = 1'b1;
    idle(1);
    check_reset("post");
    last_done = 1'b0;
    last_err  = 1'b0;

    for (int f = 0; f < 40; f++) begin
      int n;
      int bad;
      int ng;
      logic [7:0] flip;
      logic [7:0] g;
      logic [3:0] nib;
      n = $urandom_range(0, 8);
      words_q.delete();
      for (int i = 0; i < n; i++)
        words_q.push_back(20'($urandom));
      bad  = -1;
      flip = 8'h00;
      nib  = 4'($urandom_range(1, 15));
      case ($urandom_range(0, 4))
        0: if (n > 0) bad = $urandom_range(0, n - 1);
        1: flip = 8'($urandom_range(1, 255));
        default: ;
      endcase
      ng = $urandom_range(0, 3);
      for (int k = 0; k < ng; k++) begin
        g = 8'($urandom);
        if (g == SYNC_BYTE) g = 8'h5A;
        gsend(g, 2);
      end
      if (ng > 0) begin
        check("idle_done", done, last_done);
        check("idle_error", error, last_err);
      end
      run_frame(bad, nib, flip, 3);
    end

    words_q.delete();
    for (int i = 0; i < 255; i++)
      words_q.push_back(20'($urandom));
    run_frame(-1, 4'h0, 8'h00, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory: receives a framed byte stream from a host link (UART/JTAG bridge), assembles 20-bit instruction words, and writes them into instruction memory at consecutive addresses.
- Holds the pipeline core in reset while loading. Releases the core only after a successful checksum check.
- Sits between the host byte receiver and the instruction memory write port, alongside the datapath.

Parameters:
- DATA_WIDTH, 20, instruction word width. Fixed at 20; three bytes per word.
- ADDRESS_WIDTH, 8, instruction memory address width.
- TIMEOUT_CYCLES, 1000000, idle cycles allowed between bytes inside a frame before abort.
- HOLD_ON_RESET, 1. When 1, cpu_rst_n is low after reset until a load completes. When 0, cpu_rst_n is high after reset.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- rx_valid  in  1  byte available from the host receiver.
- rx_data  in  8  byte value.
- rx_ready  out  1  loader can accept a byte; transfer occurs when rx_valid && rx_ready at a rising edge.
- imem_we  out  1  instruction memory write strobe, one cycle per word.
- imem_addr  out  ADDRESS_WIDTH  write address.
- imem_wdata  out  DATA_WIDTH  write data.
- cpu_rst_n  out  1  active-low reset to the datapath.
- busy  out  1  frame in progress.
- done  out  1  last frame loaded successfully (sticky until the next sync byte).
- error  out  1  last frame failed (sticky until the next sync byte).
- words_loaded  out  ADDRESS_WIDTH  words written in the current or last frame.

Behaviour:
- Reset is asynchronous, active-low: one clock, rst asynchronous active-low.
- Reset values:
  - state = IDLE
  - rx_ready = 1
  - imem_we = 0
  - imem_addr = 0
  - imem_wdata = 0
  - cpu_rst_n = ~HOLD_ON_RESET
  - busy = 0, done = 0, error = 0
  - words_loaded = 0
  - checksum accumulator = 0
  - timeout counter = 0
- Frame format: SYNC (0xA5), COUNT N (0..255), N words × 3 bytes, CHK.
  - Each word is sent little-endian: b0 = [7:0], b1 = [15:8], b2 = [19:16] in the low nibble.
  - The high nibble of b2 must be 0.
  - CHK = XOR of COUNT and all data bytes.
- IDLE / DONE / ERROR:
  - rx_ready = 1. Bytes other than 0xA5 are consumed and ignored.
  - An accepted 0xA5 goes to COUNT and sets busy = 1, cpu_rst_n = 0, done = 0, error = 0, words_loaded = 0, imem_addr = 0, checksum = 0.
- COUNT: accepted byte loads the remaining counter and the checksum. N = 0 goes to CHECK; otherwise go to B0.
- B0, B1: accepted byte is stored in the assembly register and XORed into the checksum. Advance to the next byte state.
- B2: accepted byte with a nonzero high nibble goes to ERROR. Otherwise latch imem_wdata = {b2[3:0], b1, b0} and go to WRITE.
- WRITE (exactly 1 cycle):
  - rx_ready = 0, imem_we = 1, address and data stable.
  - Next edge: imem_addr++ (wraps at 2^ADDRESS_WIDTH), words_loaded++, remaining--.
  - remaining reaching 0 goes to CHECK; otherwise B0.
- CHECK: accepted byte equal to the accumulator goes to DONE with cpu_rst_n = 1, done = 1, busy = 0. A mismatch goes to ERROR.
- ERROR: error = 1, busy = 0, cpu_rst_n = 0. Memory contents already written are left as-is.
- Timeout:
  - The counter counts cycles in COUNT, B0, B1, B2 and CHECK without an accepted byte. It clears on every accepted byte.
  - Reaching TIMEOUT_CYCLES goes to ERROR.
- A 0xA5 byte inside a frame is plain data, not a resync.
- Latency: the imem_we pulse is asserted in the cycle after b2 is accepted. Maximum throughput is one word per 4 cycles.
- All outputs are registered. imem_we is never high outside WRITE.
- Reset mid-frame aborts immediately. Outputs return to their reset values; partially written memory is not restored.

Decomposition:
- loader_pkg:
  - state enum {IDLE, COUNT, B0, B1, B2, WRITE, CHECK, DONE, ERROR}
  - SYNC_BYTE = 8'hA5
  - BYTES_PER_WORD = 3
- One sub-module, loader_timeout: a cycle counter with clear/enable inputs and an expired output, parameterised by TIMEOUT_CYCLES.

Test Plan:
1. Reset with HOLD_ON_RESET = 1 -> cpu_rst_n = 0, rx_ready = 1, all other outputs 0.
2. Good two-word frame A5 02 45 23 01 DE BC 0A 0D -> expected response:
   - imem_we pulses with addr 0 data 0x12345, then addr 1 data 0xABCDE
   - done = 1, cpu_rst_n = 1, words_loaded = 2
3. Same frame with CHK = 0x0E -> error = 1, cpu_rst_n = 0, done = 0. Both memory writes still occurred.
4. Frame A5 01 FF FF 1F -> no imem_we, error = 1 (high nibble of b2 nonzero).
5. Frame A5 00 00 -> done = 1 with no writes. Then send garbage 0x33 -> ignored, done stays 1.
6. With TIMEOUT_CYCLES = 16, send A5 01 45 and stall rx_valid for 16 cycles -> error = 1. Pulsing rst low in B1 of another frame -> immediate return to reset values.
